// File: rtl/player_motion_sequencer.sv
// player_motion_sequencer
// Per-frame motion controller that sits in front of player_register. When a
// frame tick arrives it latches the debounced keys. It rotates first and then
// asks the map collision unit whether the cell ahead is free. It moves forward
// only if the path is clear. Each frame produces at most one motion burst, and
// rotate and forward are never driven in the same clock.
//
// Ports
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   frame_tick     one-clock pulse at frame start
//   key_fwd        forward key level (debounced)
//   key_rot        rotate key level (debounced)
//   coll_ack       collision unit response valid
//   coll_blocked   wall ahead, qualified by coll_ack
//   rotate         to player_register.rotate
//   forward        to player_register.forward
//   coll_req       collision query request
//   busy           high in any state other than IDLE
//   move_done      one-clock pulse when a frame's command finishes
//   blocked        result of the last collision check (1 = move suppressed)
//   timeout_flag   sticky, set when the collision unit fails to answer
//   overrun_count  saturating count of frame ticks dropped while busy
//
// state  | meaning
// IDLE   | waiting for frame_tick; keys latched on the tick
// ROTATE | rotate held high for ROT_STEPS clocks
// CHECK  | coll_req high until ack or ACK_TIMEOUT clocks
// MOVE   | forward held high for FWD_STEPS clocks
// DONE   | move_done pulse, back to IDLE next clock

module player_motion_sequencer #(
  parameter int ROT_STEPS   = 3,
  parameter int FWD_STEPS   = 2,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             key_fwd,
  input  logic             key_rot,
  input  logic             coll_ack,
  input  logic             coll_blocked,
  output logic             rotate,
  output logic             forward,
  output logic             coll_req,
  output logic             busy,
  output logic             move_done,
  output logic             blocked,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] overrun_count
);

  // The shared down-counter only ever holds step counts that are
  // (parameter - 1), so 8 bits is enough for the default parameters.
  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] ROT_LOAD = TMR_W'(ROT_STEPS - 1);
  localparam logic [TMR_W-1:0] FWD_LOAD = TMR_W'(FWD_STEPS - 1);
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROTATE = 3'd1,
    CHECK  = 3'd2,
    MOVE   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             fwd_l, fwd_l_nxt;
  logic             blocked_nxt, timeout_nxt;
  logic [CNT_W-1:0] ovr_nxt;

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    fwd_l_nxt   = fwd_l;
    blocked_nxt = blocked;
    timeout_nxt = timeout_flag;
    ovr_nxt     = overrun_count;

    if (frame_tick && (state != IDLE) && (overrun_count != '1))
      ovr_nxt = overrun_count + CNT_W'(1);

    case (state)
      IDLE: begin
        if (frame_tick) begin
          fwd_l_nxt = key_fwd;
          if (key_rot) begin
            state_nxt = ROTATE;
            tmr_nxt   = ROT_LOAD;
          end else if (key_fwd) begin
            state_nxt = CHECK;
            tmr_nxt   = ACK_LOAD;
          end
        end
      end
      ROTATE: begin
        if (tmr == '0) begin
          if (fwd_l) begin
            state_nxt = CHECK;
            tmr_nxt   = ACK_LOAD;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      CHECK: begin
        // An ack in the last counted clock still wins over the timeout.
        if (coll_ack) begin
          blocked_nxt = coll_blocked;
          if (coll_blocked) begin
            state_nxt = DONE;
          end else begin
            state_nxt = MOVE;
            tmr_nxt   = FWD_LOAD;
          end
        end else if (tmr == '0) begin
          blocked_nxt = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      MOVE: begin
        if (tmr == '0) state_nxt = DONE;
        else           tmr_nxt   = tmr - TMR_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered, so each
  // output is high exactly while the FSM is in the corresponding state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      tmr           <= '0;
      fwd_l         <= 1'b0;
      rotate        <= 1'b0;
      forward       <= 1'b0;
      coll_req      <= 1'b0;
      busy          <= 1'b0;
      move_done     <= 1'b0;
      blocked       <= 1'b0;
      timeout_flag  <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_nxt;
      tmr           <= tmr_nxt;
      fwd_l         <= fwd_l_nxt;
      rotate        <= (state_nxt == ROTATE);
      forward       <= (state_nxt == MOVE);
      coll_req      <= (state_nxt == CHECK);
      busy          <= (state_nxt != IDLE);
      move_done     <= (state_nxt == DONE);
      blocked       <= blocked_nxt;
      timeout_flag  <= timeout_nxt;
      overrun_count <= ovr_nxt;
    end
  end

endmodule
